pulse_to_level_fsm: RTL

- Converts single-cycle strobes back into level pulses of fixed width, so a downstream rising-edge detector recovers exactly one pulse per strobe.
- Each accepted strobe produces a HIGH_LEN-cycle high level, then a mandatory GAP_LEN-cycle low gap, which guarantees a distinct rising edge per strobe.
- Strobes that arrive while a level or gap is in progress are queued in a saturating pending counter and replayed back-to-back.

---
 rtl/pulse_to_level_fsm.sv | 120 ++++++++++++
 1 files changed

// File: rtl/pulse_to_level_fsm.sv
// Stretches single-cycle strobes into HIGH_LEN-cycle levels separated by GAP_LEN low cycles.
// Strobes arriving during a level or gap are queued in a saturating counter and replayed.
module pulse_to_level_fsm #(
    parameter int unsigned HIGH_LEN = 4,
    parameter int unsigned GAP_LEN  = 2,
    parameter int unsigned MAX_PEND = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in,
    input  logic                              clr_ovf,
    output logic                              out,
    output logic                              busy,
    output logic [$clog2(MAX_PEND+1)-1:0]     pend_cnt,
    output logic                              ovf
);

    localparam int unsigned MAX_LEN = (HIGH_LEN > GAP_LEN) ? HIGH_LEN : GAP_LEN;
    localparam int unsigned CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned PEND_W  = $clog2(MAX_PEND + 1);

    localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(HIGH_LEN - 1);
    localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_LEN - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_PEND);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHigh = 2'd1,
        StGap  = 2'd2
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [PEND_W-1:0]   r_pend;
    logic                r_ovf;
    logic                r_out;
    logic                r_busy;

    logic w_cnt_zero;
    logic w_pend_full;
    logic w_pend_nz;
    logic w_take;
    logic w_replay;

    assign w_cnt_zero  = (r_cnt == '0);
    assign w_pend_full = (r_pend == PEND_MAX);
    assign w_pend_nz   = (r_pend != '0);

    // A strobe is queued unless it is consumed directly at the end of an empty gap.
    assign w_take   = in && ((r_state == StHigh) || ((r_state == StGap) && !w_cnt_zero));
    assign w_replay = (r_state == StGap) && w_cnt_zero && w_pend_nz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_pend  <= '0;
            r_ovf   <= 1'b0;
            r_out   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (in) begin
                        r_state <= StHigh;
                        r_cnt   <= HIGH_LOAD;
                        r_out   <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                StHigh: begin
                    if (w_cnt_zero) begin
                        r_state <= StGap;
                        r_cnt   <= GAP_LOAD;
                        r_out   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                StGap: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (w_pend_nz || in) begin
                        r_state <= StHigh;
                        r_cnt   <= HIGH_LOAD;
                        r_out   <= 1'b1;
                    end else begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_cnt   <= '0;
                    r_out   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase

            // Replay with a coincident strobe nets to zero change and never drops.
            if (w_replay && !in) begin
                r_pend <= r_pend - 1'b1;
            end else if (w_take && !w_pend_full) begin
                r_pend <= r_pend + 1'b1;
            end

            if (w_take && w_pend_full) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign out      = r_out;
    assign busy     = r_busy;
    assign pend_cnt = r_pend;
    assign ovf      = r_ovf;

endmodule
